// File: rtl/pipelined_subtractor.sv
// pipelined_subtractor: diff = a - b - bin via carry-select blocks and a Kogge-Stone block-carry prefix.
// Latency 4 clk from input transfer to valid_out; 1 op/clk; all stages hold while valid_out & ~ready_out.
// Optional macro SUB_FLAGS_EN adds the {N,Z,C,V} flags output, kept aligned with diff.
module pipelined_subtractor #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int NB  = WIDTH / BLOCK;
  localparam int MSB = WIDTH - 1;

  generate
    if (((WIDTH % BLOCK) != 0) || (NB < 2)) begin : g_bad_cfg
      $error("pipelined_subtractor: WIDTH must be a multiple of BLOCK with at least two blocks");
    end
  endgenerate

  // One global advance: the whole pipe moves unless a finished result is waiting on downstream.
  logic adv;
  assign adv      = ~valid_out | ready_out;
  assign ready_in = adv;

  // ---------------- Stage 1: capture a, ~b, ~bin ----------------
  logic             s1_vld;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_nb;
  logic             s1_cin;
`ifdef SUB_FLAGS_EN
  logic             s1_amsb;
  logic             s1_bmsb;
`endif

  // Stage 1 register: subtraction becomes addition of the inverted subtrahend with carry-in ~bin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_a    <= '0;
      s1_nb   <= '0;
      s1_cin  <= 1'b0;
`ifdef SUB_FLAGS_EN
      s1_amsb <= 1'b0;
      s1_bmsb <= 1'b0;
`endif
    end else if (adv) begin
      s1_vld  <= valid_in;
      s1_a    <= a;
      s1_nb   <= ~b;
      s1_cin  <= ~bin;
`ifdef SUB_FLAGS_EN
      s1_amsb <= a[MSB];
      s1_bmsb <= b[MSB];
`endif
    end
  end

  // ---------------- Stage 2: per-block sums for both carry-ins ----------------
  logic [WIDTH-1:0] s2_sum0_d;
  logic [WIDTH-1:0] s2_sum1_d;
  logic [NB-1:0]    s2_g_d;
  logic [NB-1:0]    s2_p_d;

  // Block sums with cin=0 and cin=1; G = carry with cin=0, P = carry only appears with cin=1.
  always_comb begin
    logic [BLOCK:0] t0;
    logic [BLOCK:0] t1;
    t0        = '0;
    t1        = '0;
    s2_sum0_d = '0;
    s2_sum1_d = '0;
    s2_g_d    = '0;
    s2_p_d    = '0;
    for (int k = 0; k < NB; k++) begin
      t0 = {1'b0, s1_a[k*BLOCK +: BLOCK]} + {1'b0, s1_nb[k*BLOCK +: BLOCK]};
      t1 = t0 + {{BLOCK{1'b0}}, 1'b1};
      s2_sum0_d[k*BLOCK +: BLOCK] = t0[BLOCK-1:0];
      s2_sum1_d[k*BLOCK +: BLOCK] = t1[BLOCK-1:0];
      s2_g_d[k] = t0[BLOCK];
      s2_p_d[k] = t1[BLOCK] ^ t0[BLOCK];
    end
  end

  logic             s2_vld;
  logic [WIDTH-1:0] s2_sum0;
  logic [WIDTH-1:0] s2_sum1;
  logic [NB-1:0]    s2_g;
  logic [NB-1:0]    s2_p;
  logic             s2_cin;
`ifdef SUB_FLAGS_EN
  logic             s2_amsb;
  logic             s2_bmsb;
`endif

  // Stage 2 register: block sums and block generate/propagate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_sum0 <= '0;
      s2_sum1 <= '0;
      s2_g    <= '0;
      s2_p    <= '0;
      s2_cin  <= 1'b0;
`ifdef SUB_FLAGS_EN
      s2_amsb <= 1'b0;
      s2_bmsb <= 1'b0;
`endif
    end else if (adv) begin
      s2_vld  <= s1_vld;
      s2_sum0 <= s2_sum0_d;
      s2_sum1 <= s2_sum1_d;
      s2_g    <= s2_g_d;
      s2_p    <= s2_p_d;
      s2_cin  <= s1_cin;
`ifdef SUB_FLAGS_EN
      s2_amsb <= s1_amsb;
      s2_bmsb <= s1_bmsb;
`endif
    end
  end

  // ---------------- Stage 3: block-carry prefix ----------------
  logic [NB-1:0] s3_carry_d;

  // Kogge-Stone over block G/P. The carry-in is folded into block 0 so that after the prefix
  // each G[k] is the carry out of block k.
  always_comb begin
    logic [NB-1:0] gk;
    logic [NB-1:0] pk;
    logic [NB-1:0] gn;
    logic [NB-1:0] pn;
    gk    = s2_g;
    pk    = s2_p;
    gk[0] = s2_g[0] | (s2_p[0] & s2_cin);
    pk[0] = 1'b0;
    gn    = gk;
    pn    = pk;
    for (int d = 1; d < NB; d = d * 2) begin
      gn = gk;
      pn = pk;
      for (int k = d; k < NB; k++) begin
        gn[k] = gk[k] | (pk[k] & gk[k-d]);
        pn[k] = pk[k] & pk[k-d];
      end
      gk = gn;
      pk = pn;
    end
    s3_carry_d = gk;
  end

  logic             s3_vld;
  logic [WIDTH-1:0] s3_sum0;
  logic [WIDTH-1:0] s3_sum1;
  logic [NB-1:0]    s3_sel;
  logic             s3_cout;
`ifdef SUB_FLAGS_EN
  logic             s3_amsb;
  logic             s3_bmsb;
`endif

  // Stage 3 register: block k selects on the carry into it (block 0 on the original carry-in).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_vld  <= 1'b0;
      s3_sum0 <= '0;
      s3_sum1 <= '0;
      s3_sel  <= '0;
      s3_cout <= 1'b0;
`ifdef SUB_FLAGS_EN
      s3_amsb <= 1'b0;
      s3_bmsb <= 1'b0;
`endif
    end else if (adv) begin
      s3_vld  <= s2_vld;
      s3_sum0 <= s2_sum0;
      s3_sum1 <= s2_sum1;
      s3_sel  <= {s3_carry_d[NB-2:0], s2_cin};
      s3_cout <= s3_carry_d[NB-1];
`ifdef SUB_FLAGS_EN
      s3_amsb <= s2_amsb;
      s3_bmsb <= s2_bmsb;
`endif
    end
  end

  // ---------------- Stage 4: select and output ----------------
  logic [WIDTH-1:0] res_d;

  // Pick each block's precomputed sum according to its incoming carry.
  always_comb begin
    res_d = '0;
    for (int k = 0; k < NB; k++) begin
      res_d[k*BLOCK +: BLOCK] = s3_sel[k] ? s3_sum1[k*BLOCK +: BLOCK] : s3_sum0[k*BLOCK +: BLOCK];
    end
  end

  // Output register: borrow-out is the inverted final carry; everything holds under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
`ifdef SUB_FLAGS_EN
      flags     <= 4'b0000;
`endif
    end else if (adv) begin
      valid_out <= s3_vld;
      diff      <= res_d;
      bout      <= ~s3_cout;
`ifdef SUB_FLAGS_EN
      flags     <= {res_d[MSB], (res_d == '0), ~s3_cout,
                    (s3_amsb ^ s3_bmsb) & (s3_amsb ^ res_d[MSB])};
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Randomized and directed bench for pipelined_subtractor (WIDTH=32, BLOCK=8) against a queue-based
// arithmetic reference; checks results, ordering, 4-clk latency, stall holding and reset flushing.
module tb_pipelined_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] diff;
  logic        bout;
`ifdef SUB_FLAGS_EN
  logic [3:0]  flags;
`endif

  pipelined_subtractor #(.WIDTH(32), .BLOCK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic [3:0]  fl;
    int          acc_cyc;
    int          stalls;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          cycle  = 0;
  int          stalls = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] held_diff;
  logic        held_bout;
`ifdef SUB_FLAGS_EN
  logic [3:0]  held_flags;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // One clock cycle: drive on the falling edge, observe 1 unit later, transfers happen on the next rise.
  task automatic cyc(input logic v, input logic [31:0] aa, input logic [31:0] bb,
                     input logic bi, input logic ro, output logic acc);
    exp_t        e;
    logic [32:0] t;
    @(negedge clk);
    valid_in  = v;
    a         = aa;
    b         = bb;
    bin       = bi;
    ready_out = ro;
    #1;
    if (prev_stall) begin
      chk("hold_vld", 64'(valid_out), 64'd1);
      chk("hold_diff", 64'(diff), 64'(held_diff));
      chk("hold_bout", 64'(bout), 64'(held_bout));
`ifdef SUB_FLAGS_EN
      chk("hold_flags", 64'(flags), 64'(held_flags));
`endif
    end
    if (valid_out && !ready_out) begin
      chk("ready_in_stall", 64'(ready_in), 64'd0);
      stalls++;
    end else begin
      chk("ready_in_free", 64'(ready_in), 64'd1);
    end
    if (valid_out && ready_out) begin
      if (q.size() == 0) begin
        chk("spurious_out", 64'(valid_out), 64'd0);
      end else begin
        e = q.pop_front();
        chk("diff", 64'(diff), 64'(e.d));
        chk("bout", 64'(bout), 64'(e.bo));
`ifdef SUB_FLAGS_EN
        chk("flags", 64'(flags), 64'(e.fl));
`endif
        if (e.stalls == stalls) chk("latency", 64'(cycle - e.acc_cyc), 64'd4);
      end
    end
    prev_stall = valid_out && !ready_out;
    held_diff  = diff;
    held_bout  = bout;
`ifdef SUB_FLAGS_EN
    held_flags = flags;
`endif
    acc = v && ready_in;
    if (acc) begin
      t        = {1'b0, aa} - {1'b0, bb} - {32'd0, bi};
      e.d      = t[31:0];
      e.bo     = t[32];
      e.fl     = {e.d[31], (e.d == 32'd0), e.bo, (aa[31] ^ bb[31]) & (aa[31] ^ e.d[31])};
      e.acc_cyc = cycle;
      e.stalls  = stalls;
      q.push_back(e);
    end
    cycle++;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        acc;
    logic [31:0] da[8];
    logic [31:0] db[8];
    logic        dbin[8];
    logic [31:0] ra[8];
    logic [31:0] rb[8];
    logic        rbin[8];
    int          idx;

    rst_n = 1'b0; valid_in = 1'b0; a = '0; b = '0; bin = 1'b0; ready_out = 1'b0;
    #3;
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_diff", 64'(diff), 64'd0);
    chk("rst_bout", 64'(bout), 64'd0);
    chk("rst_ready_in", 64'(ready_in), 64'd1);
`ifdef SUB_FLAGS_EN
    chk("rst_flags", 64'(flags), 64'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases, each run alone through an empty pipe.
    da[0] = 32'h0000_0005; db[0] = 32'h0000_0003; dbin[0] = 1'b0;
    da[1] = 32'h0000_0000; db[1] = 32'h0000_0001; dbin[1] = 1'b0;
    da[2] = 32'h0000_0100; db[2] = 32'h0000_0000; dbin[2] = 1'b1;
    da[3] = 32'hA5A5_1234; db[3] = 32'hA5A5_1234; dbin[3] = 1'b0;
    da[4] = 32'hA5A5_1234; db[4] = 32'hA5A5_1234; dbin[4] = 1'b1;
    da[5] = 32'h0000_0000; db[5] = 32'hFFFF_FFFF; dbin[5] = 1'b1;
    da[6] = 32'h8000_0000; db[6] = 32'h0000_0001; dbin[6] = 1'b0;
    da[7] = 32'h1234_5678; db[7] = 32'h1234_5678; dbin[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, da[i], db[i], dbin[i], 1'b1, acc);
      chk("directed_accept", 64'(acc), 64'd1);
      drain();
    end

    // Eight back-to-back ops with ready_out low for 3 clk starting at the 6th clk.
    for (int i = 0; i < 8; i++) begin
      ra[i] = $urandom; rb[i] = $urandom; rbin[i] = ($urandom_range(0, 1) != 0);
    end
    idx = 0;
    for (int c = 0; c < 60 && !(idx == 8 && q.size() == 0); c++) begin
      if (idx < 8) cyc(1'b1, ra[idx], rb[idx], rbin[idx], !(c >= 5 && c < 8), acc);
      else         cyc(1'b0, 32'd0, 32'd0, 1'b0, !(c >= 5 && c < 8), acc);
      if (acc) idx++;
    end
    chk("burst_all_done", 64'((idx == 8) && (q.size() == 0)), 64'd1);

    // Long random run with random bubbles and random backpressure.
    for (int c = 0; c < 400; c++) begin
      cyc(($urandom_range(0, 3) != 0), $urandom, $urandom, ($urandom_range(0, 1) != 0),
          ($urandom_range(0, 3) != 0), acc);
    end
    drain();

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, $urandom, 1'b0, 1'b1, acc);
    @(negedge clk);
    valid_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", 64'(valid_out), 64'd0);
    chk("midrst_diff", 64'(diff), 64'd0);
    chk("midrst_bout", 64'(bout), 64'd0);
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
    cyc(1'b1, 32'h0000_1000, 32'h0000_0001, 1'b1, 1'b1, acc);
    chk("post_rst_accept", 64'(acc), 64'd1);
    drain();
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
